// File: rtl/spi_sram_pkg.sv
// ============================================================================
// spi_sram_pkg : opcodes, FSM state type and synchronizer reset levels
// Rev 1.0
// ============================================================================
`default_nettype none

package spi_sram_pkg;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_RD     = 3'd3,
    ST_WR     = 3'd4,
    ST_IGNORE = 3'd5
  } spi_sram_state_t;

  // Idle levels of the SPI lines, so a reset never fabricates an edge on a quiet bus
  localparam logic SYNC_RST_CS_N = 1'b1;
  localparam logic SYNC_RST_SCK  = 1'b0;
  localparam logic SYNC_RST_MOSI = 1'b0;

endpackage

`default_nettype wire

// File: rtl/spi_in_sync.sv
// ============================================================================
// spi_in_sync : 2-FF synchronizer with rise/fall detect on the synced level
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_in_sync
  import spi_sram_pkg::*;
#(
  parameter logic RST_VAL = SYNC_RST_SCK
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1   <= RST_VAL;
      r_s2   <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_s1   <= i_d;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign o_q    = r_s2;
  assign o_rise = r_s2 & ~r_prev;
  assign o_fall = ~r_s2 & r_prev;

endmodule

`default_nettype wire

// File: rtl/spi_sram_slave.sv
// ============================================================================
// spi_sram_slave : SPI mode-0 serial SRAM (READ 0x03 / WRITE 0x02), flop array
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_sram_slave
  import spi_sram_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_cs_n,
  input  logic spi_sck,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic bad_cmd,
  output logic busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic w_cs_q;
  logic w_cs_fall;
  logic w_cs_rise_unused;
  logic w_sck_q_unused;
  logic w_sck_rise;
  logic w_sck_fall;

  spi_in_sync #(.RST_VAL(SYNC_RST_CS_N)) u_cs_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (spi_cs_n),
    .o_q    (w_cs_q),
    .o_rise (w_cs_rise_unused),
    .o_fall (w_cs_fall)
  );

  spi_in_sync #(.RST_VAL(SYNC_RST_SCK)) u_sck_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (spi_sck),
    .o_q    (w_sck_q_unused),
    .o_rise (w_sck_rise),
    .o_fall (w_sck_fall)
  );

  spi_sram_state_t   r_state;
  logic [2:0]        r_bit_cnt;
  logic [6:0]        r_shift;
  logic [7:0]        r_tx;
  logic [ADDR_W-1:0] r_addr;
  logic              r_is_read;
  logic              r_wr_pend;
  logic [7:0]        r_wdata;
  logic              r_miso;
  logic              r_bad_cmd;
  logic              r_busy;
  logic              r_armed;
  logic [1:0]        r_settle;
  logic              r_mosi_s1;
  logic              r_mosi_s2;
  logic [7:0]        r_mem [DEPTH];

  logic [7:0]        w_byte;
  logic [ADDR_W-1:0] w_addr_next;
  logic [ADDR_W-1:0] w_addr_inc;

  assign w_byte      = {r_shift, r_mosi_s2};
  // Shifting the address straight into ADDR_W bits drops the unused upper bits
  assign w_addr_next = ADDR_W'({r_addr, r_mosi_s2});
  assign w_addr_inc  = r_addr + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= 3'd0;
      r_shift   <= 7'd0;
      r_tx      <= 8'd0;
      r_addr    <= '0;
      r_is_read <= 1'b0;
      r_wr_pend <= 1'b0;
      r_wdata   <= 8'd0;
      r_miso    <= 1'b0;
      r_bad_cmd <= 1'b0;
      r_busy    <= 1'b0;
      r_armed   <= 1'b0;
      r_settle  <= 2'b00;
      r_mosi_s1 <= SYNC_RST_MOSI;
      r_mosi_s2 <= SYNC_RST_MOSI;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'd0;
      end
    end else begin
      r_bad_cmd <= 1'b0;
      r_mosi_s1 <= spi_mosi;
      r_mosi_s2 <= r_mosi_s1;
      // A transaction already in flight at reset release is skipped until CS is seen high
      r_settle  <= {r_settle[0], 1'b1};
      if (r_settle[1] && w_cs_q) begin
        r_armed <= 1'b1;
      end

      if (r_wr_pend) begin
        r_mem[r_addr] <= r_wdata;
        r_addr        <= w_addr_inc;
        r_wr_pend     <= 1'b0;
      end

      if (r_state != ST_IDLE && w_cs_q) begin
        r_state   <= ST_IDLE;
        r_busy    <= 1'b0;
        r_bit_cnt <= 3'd0;
        r_shift   <= 7'd0;
        r_miso    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (r_armed && w_cs_fall) begin
              r_state   <= ST_CMD;
              r_busy    <= 1'b1;
              r_bit_cnt <= 3'd0;
              r_shift   <= 7'd0;
            end
          end
          ST_CMD: begin
            if (w_sck_rise) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_shift   <= w_byte[6:0];
              if (r_bit_cnt == 3'd7) begin
                if (w_byte == SPI_CMD_READ) begin
                  r_state   <= ST_ADDR;
                  r_is_read <= 1'b1;
                end else if (w_byte == SPI_CMD_WRITE) begin
                  r_state   <= ST_ADDR;
                  r_is_read <= 1'b0;
                end else begin
                  r_state   <= ST_IGNORE;
                  r_bad_cmd <= 1'b1;
                end
              end
            end
          end
          ST_ADDR: begin
            if (w_sck_rise) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_addr    <= w_addr_next;
              if (r_bit_cnt == 3'd7) begin
                if (r_is_read) begin
                  r_state <= ST_RD;
                  r_tx    <= r_mem[w_addr_next];
                end else begin
                  r_state <= ST_WR;
                end
              end
            end
          end
          ST_RD: begin
            if (w_sck_fall) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_miso    <= r_tx[7];
              if (r_bit_cnt == 3'd7) begin
                r_addr <= w_addr_inc;
                r_tx   <= r_mem[w_addr_inc];
              end else begin
                r_tx <= {r_tx[6:0], 1'b0};
              end
            end
          end
          ST_WR: begin
            if (w_sck_rise) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_shift   <= w_byte[6:0];
              if (r_bit_cnt == 3'd7) begin
                r_wdata   <= w_byte;
                r_wr_pend <= 1'b1;
              end
            end
          end
          ST_IGNORE: begin
            r_state <= ST_IGNORE;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign spi_miso = r_miso;
  assign bad_cmd  = r_bad_cmd;
  assign busy     = r_busy;

endmodule

`default_nettype wire
